multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/riscv_pkg.sv | 58 +++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 150 +++++++++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: FSM states, opcodes,
// ALU control codes and datapath mux select codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's internal ALUOp plus instruction funct fields onto the
// 3-bit ALUControl code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op[5] distinguishes R-type from addi, whose bit 30 is immediate data
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I-subset datapath: sequences fetch,
// decode, memory, execute and writeback, and drives the datapath controls.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       mem_write_s, ir_write_s, reg_write_s, illegal_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        illegal_s = !op_supported(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  // Strobes are gated by rst_n so nothing can write while reset is held.
  assign PCWrite  = rst_n & (pc_update | (branch & zero));
  assign MemWrite = rst_n & mem_write_s;
  assign IRWrite  = rst_n & ir_write_s;
  assign RegWrite = rst_n & reg_write_s;
  assign illegal  = rst_n & illegal_s;
  assign state_o  = state_q;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// control sequences built from the instruction-level behaviour.
module tb_multicycle_controller;
  import riscv_pkg::*;

  localparam int W = 21;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .illegal(illegal), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] pack(input logic [3:0] st, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
      input logic rw, input logic [2:0] aluc, input logic ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, imm, rw, aluc, ill};
  endfunction

  function automatic logic [W-1:0] observed();
    return pack(state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal);
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 2'd1;       // store: S immediate
    if (o == 7'b1100011) return 2'd2;       // branch: B immediate
    if (o == 7'b1101111) return 2'd3;       // jal: J immediate
    return 2'd0;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'd0: return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
  endfunction

  // Push the whole expected cycle-by-cycle control trace of one instruction.
  task automatic build_expected(input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic z);
    logic [1:0] im;
    logic [2:0] ex;
    im = imm_ref(o);
    ex = alu_ref(o, f3, f7);
    exp_q.push_back(pack(S_FETCH, 1, 0, 0, 1, 2'd2, 2'd0, 2'd2, im, 0, 3'd0, 0));
    exp_q.push_back(pack(S_DECODE, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, im, 0, 3'd0, !is_legal(o)));
    case (o)
      7'b0000011: begin
        exp_q.push_back(pack(S_MEMADR, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, im, 0, 3'd0, 0));
        exp_q.push_back(pack(S_MEMREAD, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, im, 0, 3'd0, 0));
        exp_q.push_back(pack(S_MEMWB, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, im, 1, 3'd0, 0));
      end
      7'b0100011: begin
        exp_q.push_back(pack(S_MEMADR, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, im, 0, 3'd0, 0));
        exp_q.push_back(pack(S_MEMWRITE, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, im, 0, 3'd0, 0));
      end
      7'b0110011: begin
        exp_q.push_back(pack(S_EXECR, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, im, 0, ex, 0));
        exp_q.push_back(pack(S_ALUWB, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, im, 1, 3'd0, 0));
      end
      7'b0010011: begin
        exp_q.push_back(pack(S_EXECI, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, im, 0, ex, 0));
        exp_q.push_back(pack(S_ALUWB, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, im, 1, 3'd0, 0));
      end
      7'b1101111: begin
        exp_q.push_back(pack(S_JAL, 1, 0, 0, 0, 2'd0, 2'd1, 2'd2, im, 0, 3'd0, 0));
        exp_q.push_back(pack(S_ALUWB, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, im, 1, 3'd0, 0));
      end
      7'b1100011:
        exp_q.push_back(pack(S_BEQ, z, 0, 0, 0, 2'd0, 2'd2, 2'd0, im, 0, 3'b001, 0));
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Entered #1 after a rising edge with the DUT in FETCH; leaves the same way.
  task automatic run_instr(input string name, input logic [6:0] o,
                           input logic [2:0] f3, input logic f7, input logic z);
    logic [W-1:0] e;
    int cyc;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build_expected(o, f3, f7, z);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cyc++;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h required %h", name, cyc, observed(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (observed() !== pack(S_FETCH, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 3'd0, 0)) begin
      errors++;
      $display("FAIL reset_hold: got %h", observed());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();       run_instr("lw", 7'b0000011, 3'd2, 1'b0, 1'b0); endtask
  task automatic test_sw();       run_instr("sw", 7'b0100011, 3'd2, 1'b1, 1'b1); endtask
  task automatic test_rtype_sub(); run_instr("r_sub", 7'b0110011, 3'd0, 1'b1, 1'b0); endtask
  task automatic test_itype_add(); run_instr("i_addi", 7'b0010011, 3'd0, 1'b1, 1'b0); endtask
  task automatic test_jal();      run_instr("jal", 7'b1101111, 3'd5, 1'b0, 1'b0); endtask

  task automatic test_beq();
    run_instr("beq_taken", 7'b1100011, 3'd0, 1'b0, 1'b1);
    run_instr("beq_not_taken", 7'b1100011, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 7'b1111111, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    op = 7'b0110011; funct3 = 3'd7; funct7b5 = 1'b0; zero = 1'b1;
    build_expected(op, funct3, funct7b5, zero);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d: got %h required %h", i + 1, observed(), e);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
    exp_q.delete();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== pack(S_FETCH, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 3'd0, 0)) begin
      errors++;
      $display("FAIL reset_mid_async: got %h", observed());
    end
    @(posedge clk); #1;
    checks++;
    if (observed() !== pack(S_FETCH, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 3'd0, 0)) begin
      errors++;
      $display("FAIL reset_mid_held: got %h", observed());
    end
    rst_n = 1'b1;
    run_instr("after_reset_r_and", 7'b0110011, 3'd7, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [6:0] legal_ops [6];
    logic [6:0] o;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        o = 7'($urandom_range(0, 127));
        while (is_legal(o)) o = 7'($urandom_range(0, 127));
      end else begin
        o = legal_ops[$urandom_range(0, 5)];
      end
      run_instr("random", o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_sub();
    test_itype_add();
    test_jal();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
